// File: rtl/eit_meas_pkg.sv
// Shared FSM encoding and interface widths for the EIT measurement chain.
// Imported by the measurement accumulator and its cycle timer.
package eit_meas_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CONVERT = 3'd2,
    ST_WAIT    = 3'd3,
    ST_OUTPUT  = 3'd4
  } meas_state_t;

  localparam int ADC_W  = 16;
  localparam int STEP_W = 8;
  localparam int TMR_W  = 16;

  // Accumulator grows by log2(N) bits so a full run of extreme samples cannot wrap.
  function automatic int acc_width(input int num_samples);
    return ADC_W + $clog2(num_samples);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter shared by the settle delay and the ADC timeout.
// o_expired is high while the count sits at zero.
module cycle_timer
  import eit_meas_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/meas_accumulator.sv
// Per-step ADC averaging: settle, run NUM_SAMPLES conversions, present the
// arithmetic mean (floor) with the step index on a valid/ready result port.
module meas_accumulator
  import eit_meas_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 64,
  parameter int NUM_SAMPLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step_done,
  input  logic [STEP_W-1:0]        mux_cmd,
  output logic                     adc_conv,
  input  logic signed [ADC_W-1:0]  adc_data,
  input  logic                     adc_valid,
  output logic signed [ADC_W-1:0]  res_data,
  output logic [STEP_W-1:0]        res_step,
  output logic                     res_err,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     busy,
  output logic                     overrun
);

  localparam int LOG2N = $clog2(NUM_SAMPLES);
  localparam int ACC_W = acc_width(NUM_SAMPLES);
  localparam int CNT_W = LOG2N + 1;

  // The timer reads zero on the last cycle of each interval, hence the -1 loads.
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LD    = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_SAMPLES - 1);

  meas_state_t r_state;
  meas_state_t w_state_nxt;

  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic signed [ADC_W-1:0]  r_res_data;
  logic [STEP_W-1:0]        r_res_step;
  logic                     r_res_err;
  logic                     r_overrun;

  logic                     w_tmr_load;
  logic [TMR_W-1:0]         w_tmr_val;
  logic                     w_tmr_en;
  logic                     w_tmr_expired;
  logic                     w_start;
  logic                     w_sample;
  logic                     w_last;
  logic                     w_timeout;
  logic signed [ACC_W-1:0]  w_acc_sum;

  function automatic logic signed [ADC_W-1:0] avg_trunc(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] shifted;
    shifted = acc >>> LOG2N;
    return shifted[ADC_W-1:0];
  endfunction

  cycle_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_expired  (w_tmr_expired)
  );

  assign w_acc_sum = r_acc + ACC_W'(adc_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = SETTLE_LD;
    w_tmr_en    = 1'b0;
    w_start     = 1'b0;
    w_sample    = 1'b0;
    w_last      = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (step_done) begin
          w_start     = 1'b1;
          w_tmr_load  = 1'b1;
          w_tmr_val   = SETTLE_LD;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (w_tmr_expired) begin
          w_state_nxt = ST_CONVERT;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      ST_CONVERT: begin
        w_tmr_load  = 1'b1;
        w_tmr_val   = TMO_LD;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // A sample landing on the final timeout cycle still counts.
        if (adc_valid) begin
          w_sample = 1'b1;
          if (r_cnt == LAST_CNT) begin
            w_last      = 1'b1;
            w_state_nxt = ST_OUTPUT;
          end else begin
            w_state_nxt = ST_CONVERT;
          end
        end else if (w_tmr_expired) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_OUTPUT;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      ST_OUTPUT: begin
        if (res_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_res_data <= '0;
      r_res_step <= '0;
      r_res_err  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= step_done && (r_state != ST_IDLE);
      if (w_start) begin
        r_acc      <= '0;
        r_cnt      <= '0;
        r_res_step <= mux_cmd;
        r_res_err  <= 1'b0;
      end else if (w_sample) begin
        r_acc <= w_acc_sum;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_res_data <= avg_trunc(w_acc_sum);
        end
      end else if (w_timeout) begin
        r_res_err  <= 1'b1;
        r_res_data <= '0;
      end
    end
  end

  assign adc_conv  = (r_state == ST_CONVERT);
  assign res_valid = (r_state == ST_OUTPUT);
  assign busy      = (r_state != ST_IDLE);
  assign overrun   = r_overrun;
  assign res_data  = r_res_data;
  assign res_step  = r_res_step;
  assign res_err   = r_res_err;

endmodule

// File: tb/tb_meas_accumulator.sv
// Directed bench for meas_accumulator: SETTLE=4, NUM_SAMPLES=4, TIMEOUT=8,
// with a behavioural ADC of configurable latency and optional silence.
module tb_meas_accumulator;

  logic               clk;
  logic               rst;
  logic               step_done;
  logic [7:0]         mux_cmd;
  logic               adc_conv;
  logic signed [15:0] adc_data;
  logic               adc_valid;
  logic signed [15:0] res_data;
  logic [7:0]         res_step;
  logic               res_err;
  logic               res_valid;
  logic               res_ready;
  logic               busy;
  logic               overrun;

  int n_chk;
  int n_fail;
  int cyc;
  int step_cyc;
  int conv_cnt;
  int first_conv;
  int last_conv;
  int rise;

  logic signed [15:0] adc_vals [8];
  int adc_idx;
  int adc_k;
  int adc_lat;
  int adc_mute_at;

  meas_accumulator #(
    .SETTLE_CYCLES  (4),
    .NUM_SAMPLES    (4),
    .TIMEOUT_CYCLES (8)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .step_done (step_done),
    .mux_cmd   (mux_cmd),
    .adc_conv  (adc_conv),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .res_data  (res_data),
    .res_step  (res_step),
    .res_err   (res_err),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin : conv_monitor
    forever begin
      @(negedge clk);
      if (adc_conv === 1'b1) begin
        conv_cnt++;
        last_conv = cyc;
        if (first_conv < 0) first_conv = cyc;
      end
    end
  end

  // Answers conversion k after adc_lat cycles unless k >= adc_mute_at.
  initial begin : adc_model
    adc_valid = 1'b0;
    adc_data  = '0;
    forever begin
      @(negedge clk);
      if (adc_conv === 1'b1) begin
        adc_k = adc_idx;
        adc_idx++;
        if (adc_k < adc_mute_at) begin
          repeat (adc_lat) @(posedge clk);
          #1;
          adc_valid = 1'b1;
          adc_data  = adc_vals[adc_k];
          @(posedge clk);
          #1;
          adc_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
    $fatal(1, "bench time limit");
  end

  task automatic check_val(input string tag, input logic signed [31:0] act,
                           input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic set_vals(input logic signed [15:0] a, input logic signed [15:0] b,
                          input logic signed [15:0] c, input logic signed [15:0] d);
    adc_vals[0] = a;
    adc_vals[1] = b;
    adc_vals[2] = c;
    adc_vals[3] = d;
    adc_idx     = 0;
  endtask

  task automatic do_step(input logic [7:0] m);
    @(posedge clk);
    #1;
    conv_cnt   = 0;
    first_conv = -1;
    last_conv  = -1;
    step_done  = 1'b1;
    mux_cmd    = m;
    step_cyc   = cyc;
    @(posedge clk);
    #1;
    step_done = 1'b0;
    mux_cmd   = 8'h00;
  endtask

  task automatic wait_valid(input int budget, output int rise_cyc);
    rise_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        rise_cyc = cyc;
        break;
      end
    end
    check_val("res_valid_seen", res_valid, 1);
  endtask

  task automatic accept(input logic with_step);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    step_done = with_step;
    mux_cmd   = 8'h2A;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    step_done = 1'b0;
    mux_cmd   = 8'h00;
    @(negedge clk);
    check_val("valid_drop", res_valid, 0);
    if (with_step) check_val("overrun_handshake", overrun, 1);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    conv_cnt = 0;
    first_conv = -1;
    last_conv = -1;
    adc_idx = 0;
    adc_lat = 2;
    adc_mute_at = 8;
    for (int i = 0; i < 8; i++) adc_vals[i] = '0;
    rst = 1'b1;
    step_done = 1'b0;
    mux_cmd = 8'h00;
    res_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_adc_conv", adc_conv, 0);
    check_val("rst_res_valid", res_valid, 0);
    check_val("rst_res_err", res_err, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_overrun", overrun, 0);
    check_val("rst_res_data", res_data, 0);
    check_val("rst_res_step", res_step, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic average 100..400 -> 250, then a stalled consumer with an overrun
    set_vals(16'sd100, 16'sd200, 16'sd300, 16'sd400);
    do_step(8'd5);
    wait_valid(60, rise);
    check_val("t1_first_conv", first_conv - step_cyc, 5);
    check_val("t1_latency", rise - step_cyc, 17);
    check_val("t1_res_data", res_data, 250);
    check_val("t1_res_step", res_step, 5);
    check_val("t1_res_err", res_err, 0);
    check_val("t1_conv_cnt", conv_cnt, 4);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      step_done = (i == 3);
      mux_cmd   = (i == 3) ? 8'd9 : 8'd0;
      @(negedge clk);
      check_val("t1_hold_valid", res_valid, 1);
      check_val("t1_hold_data", res_data, 250);
      check_val("t1_hold_step", res_step, 5);
      if (i == 4) check_val("t1_overrun_pulse", overrun, 1);
      if (i == 5) check_val("t1_overrun_clear", overrun, 0);
    end
    @(posedge clk);
    #1;
    step_done = 1'b0;
    accept(1'b0);
    repeat (8) @(negedge clk);
    check_val("t1_no_new_conv", conv_cnt, 4);
    check_val("t1_idle", busy, 0);

    // Negative samples floor: -7 >>> 2 = -2; step_done on the handshake is refused
    set_vals(-16'sd1, -16'sd2, -16'sd2, -16'sd2);
    do_step(8'd7);
    wait_valid(60, rise);
    check_val("t2_res_data", res_data, -2);
    check_val("t2_res_step", res_step, 7);
    check_val("t2_res_err", res_err, 0);
    accept(1'b1);
    repeat (4) @(negedge clk);
    check_val("t2_not_started", busy, 0);

    // ADC silent from the second conversion: timeout after 8 WAIT cycles
    set_vals(16'sd10, 16'sd20, 16'sd30, 16'sd40);
    adc_mute_at = 1;
    do_step(8'd12);
    wait_valid(60, rise);
    check_val("t3_conv_cnt", conv_cnt, 2);
    check_val("t3_timeout_delay", rise - last_conv, 9);
    check_val("t3_res_err", res_err, 1);
    check_val("t3_res_data", res_data, 0);
    check_val("t3_res_step", res_step, 12);
    accept(1'b0);

    // Clean result after the error: (1000-1000+3+5)/4 = 2
    adc_mute_at = 8;
    set_vals(16'sd1000, -16'sd1000, 16'sd3, 16'sd5);
    do_step(8'd200);
    wait_valid(60, rise);
    check_val("t4_res_err", res_err, 0);
    check_val("t4_res_data", res_data, 2);
    check_val("t4_res_step", res_step, 200);
    accept(1'b0);

    // Samples arriving on the last timeout cycle are accepted
    adc_lat = 8;
    set_vals(16'sd4, 16'sd4, 16'sd4, 16'sd4);
    do_step(8'h11);
    wait_valid(80, rise);
    check_val("t5_latency", rise - step_cyc, 41);
    check_val("t5_res_err", res_err, 0);
    check_val("t5_res_data", res_data, 4);
    accept(1'b0);

    // Asynchronous reset while waiting for the ADC
    adc_lat = 2;
    set_vals(16'sd50, 16'sd50, 16'sd50, 16'sd50);
    do_step(8'd33);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (adc_conv === 1'b1) break;
    end
    check_val("t6_conv_seen", adc_conv, 1);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_val("t6_busy", busy, 0);
    check_val("t6_adc_conv", adc_conv, 0);
    check_val("t6_res_valid", res_valid, 0);
    check_val("t6_res_step", res_step, 0);
    check_val("t6_res_data", res_data, 0);
    check_val("t6_res_err", res_err, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_val("t6_still_idle", busy, 0);

    // Correct result after the reset
    set_vals(16'sd8, 16'sd8, 16'sd8, 16'sd8);
    do_step(8'd3);
    wait_valid(60, rise);
    check_val("t7_latency", rise - step_cyc, 17);
    check_val("t7_res_data", res_data, 8);
    check_val("t7_res_step", res_step, 3);
    check_val("t7_res_err", res_err, 0);
    accept(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
